// File: rtl/lcd_bus_responder.sv
// Responder for the 8-bit HD44780-style LCD bus. It decodes writes on the synchronised EN fall and keeps the AC and a 2x16 DDRAM shadow.
// Latency: an accepted write pulses o_cmd_valid 3 clocks after EN=0 is first sampled. Backpressure: o_busy is held per command; a write while busy is dropped and flagged on o_viol.
module lcd_bus_responder #(
  parameter int BUSY_CYC    = 2000,
  parameter int CLEAR_CYC   = 76500,
  parameter int MIN_EN_HIGH = 12
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic       LCD_RW,
  input  logic [7:0] LCD_DATA,
  output logic [7:0] o_rd_data,
  output logic       o_busy,
  output logic       o_cmd_valid,
  output logic       o_cmd_rs,
  output logic [7:0] o_cmd,
  output logic       o_viol,
  output logic       o_init_done,
  output logic       o_disp_on,
  output logic [6:0] o_ac,
  input  logic [4:0] i_peek_addr,
  output logic [7:0] o_peek_char
);

  localparam int CW = $clog2((CLEAR_CYC > BUSY_CYC) ? CLEAR_CYC : BUSY_CYC);
  localparam int EW = $clog2(MIN_EN_HIGH + 1);

  typedef enum logic [1:0] {S_IDLE, S_EN_HIGH, S_EXEC, S_BUSY} state_t;
  state_t state, state_nxt;

  logic [1:0]    en_sy, rs_sy, rw_sy;
  logic [7:0]    dat_sy0, dat_sy1;
  logic          en_s, rs_s, rw_s, en_d;
  logic [7:0]    dat_s;
  logic [EW-1:0] en_cnt;
  logic          fall, short_pulse;
  logic          cmd_rs, cmd_rw;
  logic [7:0]    cmd_dat;
  logic          exec_busy, exec_long;
  logic          latch_cmd, viol_nxt, busy_rd_step;
  logic [CW-1:0] busy_cnt;
  logic          clr_act;
  logic [4:0]    clr_idx;
  logic [6:0]    ac;
  logic          inc;
  logic          ac_vis;
  logic [4:0]    ac_idx;
  logic [7:0]    shadow [32];

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27)      return 7'h40;
      else if (a == 7'h67) return 7'h00;
      else                 return a + 7'd1;
    end else begin
      if (a == 7'h00)      return 7'h67;
      else if (a == 7'h40) return 7'h27;
      else                 return a - 7'd1;
    end
  endfunction

  assign en_s  = en_sy[1];
  assign rs_s  = rs_sy[1];
  assign rw_s  = rw_sy[1];
  assign dat_s = dat_sy1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_sy   <= '0;
      rs_sy   <= '0;
      rw_sy   <= '0;
      dat_sy0 <= '0;
      dat_sy1 <= '0;
      en_d    <= 1'b0;
      en_cnt  <= '0;
    end else begin
      en_sy   <= {en_sy[0], LCD_EN};
      rs_sy   <= {rs_sy[0], LCD_RS};
      rw_sy   <= {rw_sy[0], LCD_RW};
      dat_sy0 <= LCD_DATA;
      dat_sy1 <= dat_sy0;
      en_d    <= en_s;
      // Saturating count of EN-high cycles, cleared while EN is low
      if (en_s) begin
        if (en_cnt != EW'(MIN_EN_HIGH)) en_cnt <= en_cnt + EW'(1);
      end else begin
        en_cnt <= '0;
      end
    end
  end

  assign fall         = en_d & ~en_s;
  assign short_pulse  = (en_cnt < EW'(MIN_EN_HIGH));
  assign exec_busy    = cmd_rs | (cmd_dat != 8'h00);
  assign exec_long    = !cmd_rs && (cmd_dat[7:2] == 6'd0) && (cmd_dat[1:0] != 2'd0);
  assign busy_rd_step = (state == S_BUSY) && fall && !short_pulse && rw_s && rs_s;
  assign ac_vis       = (ac[6:4] == 3'b000) || (ac[6:4] == 3'b100);
  assign ac_idx       = {ac[6], ac[3:0]};
  assign o_busy       = (state == S_BUSY);
  assign o_ac         = ac;
  assign o_peek_char  = shadow[i_peek_addr];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_cmd = 1'b0;
    viol_nxt  = 1'b0;
    case (state)
      S_IDLE:    if (en_s) state_nxt = S_EN_HIGH;
      S_EN_HIGH: begin
        if (fall) begin
          if (short_pulse) begin
            viol_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end else begin
            latch_cmd = 1'b1;
            state_nxt = S_EXEC;
          end
        end
      end
      S_EXEC:    state_nxt = (!cmd_rw && exec_busy) ? S_BUSY : S_IDLE;
      S_BUSY: begin
        if (fall && (short_pulse || !rw_s)) viol_nxt = 1'b1;
        if (busy_cnt == '0) state_nxt = S_IDLE;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data   <= 8'h00;
      o_cmd_valid <= 1'b0;
      o_cmd_rs    <= 1'b0;
      o_cmd       <= 8'h00;
      o_viol      <= 1'b0;
      o_init_done <= 1'b0;
      o_disp_on   <= 1'b0;
      cmd_rs      <= 1'b0;
      cmd_rw      <= 1'b0;
      cmd_dat     <= 8'h00;
      busy_cnt    <= '0;
      clr_act     <= 1'b0;
      clr_idx     <= 5'd0;
      ac          <= 7'd0;
      inc         <= 1'b1;
      for (int i = 0; i < 32; i++) shadow[i] <= 8'h20;
    end else begin
      o_cmd_valid <= 1'b0;
      o_viol      <= viol_nxt;
      o_rd_data   <= rs_s ? (ac_vis ? shadow[ac_idx] : 8'h20) : {o_busy, ac};
      if (latch_cmd) begin
        cmd_rs  <= rs_s;
        cmd_rw  <= rw_s;
        cmd_dat <= dat_s;
      end
      if (state == S_BUSY) begin
        if (busy_cnt != '0) busy_cnt <= busy_cnt - CW'(1);
        // Clear display wipes one shadow entry per busy cycle
        if (clr_act) begin
          shadow[clr_idx] <= 8'h20;
          clr_idx         <= clr_idx + 5'd1;
          if (clr_idx == 5'd31) clr_act <= 1'b0;
        end
        if (busy_rd_step) ac <= ac_step(ac, inc);
      end
      if (state == S_EXEC) begin
        if (cmd_rw) begin
          if (cmd_rs) ac <= ac_step(ac, inc);
        end else begin
          o_cmd_valid <= 1'b1;
          o_cmd       <= cmd_dat;
          o_cmd_rs    <= cmd_rs;
          busy_cnt    <= exec_long ? CW'(CLEAR_CYC - 1) : CW'(BUSY_CYC - 1);
          if (cmd_rs) begin
            if (ac_vis) shadow[ac_idx] <= cmd_dat;
            ac <= ac_step(ac, inc);
          end else begin
            casez (cmd_dat)
              8'b1???????: ac <= cmd_dat[6:0];
              8'b01??????: ;
              8'b001?????: if (cmd_dat[4]) o_init_done <= 1'b1;
              8'b0001????: if (!cmd_dat[3]) ac <= ac_step(ac, cmd_dat[2]);
              8'b00001???: o_disp_on <= cmd_dat[2];
              8'b000001??: inc <= cmd_dat[1];
              8'b0000001?: ac <= 7'd0;
              8'b00000001: begin
                ac      <= 7'd0;
                inc     <= 1'b1;
                clr_act <= 1'b1;
                clr_idx <= 5'd0;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule
